// File: rtl/fir_interp.sv
// fir_interp -- 4x polyphase FIR interpolator, one multiply-accumulate per cycle.
//
// Each accepted low-rate sample x[n] produces four outputs in phase order
// p = 0..3, with y_p = sum_{j=0..7} h[4j+p] * x[n-j]. Each output takes 8 MAC
// cycles and is then held in OUT until downstream takes it.
//
// Parameters
//   DATA_W  signed input sample width
//   COEF_W  signed coefficient width
//   SHIFT   arithmetic right shift applied to the accumulator before output
//   COEFFS  32 prototype taps packed LSB-first: h[k] = COEFFS[k*COEF_W +: COEF_W]
//
// Ports
//   Clock      rising-edge clock
//   Rst_n      synchronous active-low reset
//   In_Valid   In_Data holds a sample
//   In_Data    signed low-rate sample
//   In_Ready   high only while idle; In_Valid && In_Ready accepts a sample
//   Out_Valid  Out_Data holds an interpolated sample
//   Out_Data   signed 32-bit interpolated sample
//   Out_Ready  downstream takes Out_Data
//
// Configuration macro
//   FIR_INTERP_SAT_EN  when defined, (acc >>> SHIFT) is clamped to the signed
//                      DATA_W range; otherwise bits [SHIFT+26:SHIFT] of acc
//                      are sign-extended to 32 bits without clamping.
module fir_interp #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 13,
  parameter int SHIFT  = 13,
  parameter logic [32*COEF_W-1:0] COEFFS = {32{13'sd1024}}
) (
  input  logic              Clock,
  input  logic              Rst_n,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_Data,
  output logic              In_Ready,
  output logic              Out_Valid,
  output logic [31:0]       Out_Data,
  input  logic              Out_Ready
);

  localparam int ACC_W  = 40;
  localparam int PROD_W = DATA_W + COEF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]               p_reg;
  logic [2:0]               j_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [31:0]              out_data_reg;
  logic signed [DATA_W-1:0] x_reg [8];

  logic signed [COEF_W-1:0] coef [32];
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [DATA_W-1:0] x_sel;
  logic signed [PROD_W-1:0] coef_ext, x_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext, acc_base, acc_sum;
  logic [31:0]              out_fmt;
  logic                     accept;

  // Unpack the prototype taps once so the tap index is a plain array select.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_coef
      assign coef[gi] = COEFFS[gi*COEF_W +: COEF_W];
    end
  endgenerate

  // {j, p} is exactly 4j+p, the prototype tap for this phase and delay slot.
  assign coef_sel = coef[{j_reg, p_reg}];
  assign x_sel    = x_reg[j_reg];

  // Both operands widened to the full product width so the multiply is exact.
  assign coef_ext = {{DATA_W{coef_sel[COEF_W-1]}}, coef_sel};
  assign x_ext    = {{COEF_W{x_sel[DATA_W-1]}}, x_sel};
  assign prod     = coef_ext * x_ext;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Tap 0 starts a fresh sum, so no separate accumulator clear is needed.
  assign acc_base = (j_reg == 3'd0) ? '0 : acc_reg;
  assign acc_sum  = acc_base + prod_ext;

`ifdef FIR_INTERP_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W-1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  logic signed [ACC_W-1:0] shifted;
  assign shifted = acc_sum >>> SHIFT;

  always_comb begin
    out_fmt = shifted[31:0];
    if (shifted > SAT_MAX) begin
      out_fmt = SAT_MAX[31:0];
    end else if (shifted < SAT_MIN) begin
      out_fmt = SAT_MIN[31:0];
    end
  end
`else
  // 27 bits kept above the shift point, top bit replicated to fill 32.
  assign out_fmt = {{5{acc_sum[SHIFT+26]}}, acc_sum[SHIFT+26:SHIFT]};
`endif

  assign accept = (state_reg == IDLE) && In_Valid;

  // State register
  always_ff @(posedge Clock) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_next = state_reg;
    In_Ready   = 1'b0;
    Out_Valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        In_Ready = 1'b1;
        if (In_Valid) begin
          state_next = MAC;
        end
      end
      MAC: begin
        if (j_reg == 3'd7) begin
          state_next = OUT;
        end
      end
      OUT: begin
        Out_Valid = 1'b1;
        if (Out_Ready) begin
          state_next = (p_reg == 2'd3) ? IDLE : MAC;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Phase / tap counters, accumulator and output register
  always_ff @(posedge Clock) begin
    if (!Rst_n) begin
      p_reg        <= '0;
      j_reg        <= '0;
      acc_reg      <= '0;
      out_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (In_Valid) begin
            p_reg <= '0;
            j_reg <= '0;
          end
        end
        MAC: begin
          acc_reg <= acc_sum;
          j_reg   <= j_reg + 3'd1;   // wraps 7 -> 0, ready for the next phase
          if (j_reg == 3'd7) begin
            out_data_reg <= out_fmt;
          end
        end
        OUT: begin
          if (Out_Ready && (p_reg != 2'd3)) begin
            p_reg <= p_reg + 2'd1;
          end
        end
        default: begin
          p_reg <= '0;
          j_reg <= '0;
        end
      endcase
    end
  end

  // Delay line: moves only when a sample is accepted.
  always_ff @(posedge Clock) begin
    if (!Rst_n) begin
      x_reg[0] <= '0;
    end else if (accept) begin
      x_reg[0] <= In_Data;
    end
  end

  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_dly
      always_ff @(posedge Clock) begin
        if (!Rst_n) begin
          x_reg[gi] <= '0;
        end else if (accept) begin
          x_reg[gi] <= x_reg[gi-1];
        end
      end
    end
  endgenerate

  assign Out_Data = out_data_reg;

endmodule

// File: tb/tb_fir_interp.sv
// Testbench for fir_interp: scoreboard queues of hand-computed outputs,
// drained by monitors whenever an output handshake occurs.
module tb_fir_interp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_valid2;
  logic [15:0] in_data, in_data2;
  logic        in_ready, in_ready2;
  logic        out_valid, out_valid2;
  logic [31:0] out_data, out_data2;
  logic        out_ready, out_ready2;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int n_out2   = 0;
  logic signed [31:0] exp_q[$];
  logic signed [31:0] exp2_q[$];

  always #5 clk = ~clk;

  fir_interp dut (
    .Clock(clk), .Rst_n(rst_n),
    .In_Valid(in_valid), .In_Data(in_data), .In_Ready(in_ready),
    .Out_Valid(out_valid), .Out_Data(out_data), .Out_Ready(out_ready)
  );

  fir_interp #(.COEFFS({32{13'sd4095}})) dut_big (
    .Clock(clk), .Rst_n(rst_n),
    .In_Valid(in_valid2), .In_Data(in_data2), .In_Ready(in_ready2),
    .Out_Valid(out_valid2), .Out_Data(out_data2), .Out_Ready(out_ready2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               name, $signed(act), act, $signed(req), req);
    end else begin
      $display("ok   %s: %0d", name, $signed(act));
    end
  endtask

  // Monitors: one line per output transaction.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d expected none", $signed(out_data));
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid2 && out_ready2) begin
      n_out2++;
      if (exp2_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output_big: got %0d expected none", $signed(out_data2));
      end else begin
        check("out_data_big", out_data2, exp2_q.pop_front());
      end
    end
  end

  // Called at #1 after a rising edge; returns #1 after the accept edge.
  task automatic send(input logic [15:0] s);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid = 1'b1;
    in_data  = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push4(input logic signed [31:0] v);
    for (int i = 0; i < 4; i++) exp_q.push_back(v);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1; t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  logic signed [31:0] neg_tbl [8];
  logic signed [31:0] big_tbl [8];
  int lat, t, cyc, n_acc, base_out, silent;
  int acc_cyc [3];
  int acc_out [3];

  initial begin
    neg_tbl = '{32'sd3072, -32'sd2048, -32'sd7168, -32'sd12288,
                -32'sd17408, -32'sd22528, -32'sd27648, -32'sd32768};
`ifdef FIR_INTERP_SAT_EN
    big_tbl = '{32'sd16379, 32'sd32759, 32'sd32767, 32'sd32767,
                32'sd32767, 32'sd32767, 32'sd32767, 32'sd32767};
`else
    big_tbl = '{32'sd16379, 32'sd32759, 32'sd49138, 32'sd65518,
                32'sd81897, 32'sd98277, 32'sd114656, 32'sd131036};
`endif
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);

    // Ramp of 8192 samples, first output latency measured
    push4(32'sd1024);
    send(16'sd8192);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check("first_out_latency", lat, 8);
    for (int k = 2; k <= 10; k++) begin
      push4((k > 8 ? 8 : k) * 1024);
      send(16'sd8192);
    end
    drain("drain_ramp");

    // Negative full scale, history moving from 8192 to -32768
    for (int k = 0; k < 9; k++) begin
      push4(k < 8 ? neg_tbl[k] : -32'sd32768);
      send(16'h8000);
    end
    drain("drain_neg");
    check("neg_sign_ext", out_data, 32'hFFFF8000);

    // Back-pressure: hold phase 0 output for 5 cycles
    out_ready = 1'b0;
    push4(-32'sd28672);
    send(16'sd0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data", out_data, -32'sd28672);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain("drain_stall");

    // Reset during MAC of phase 2, with a simultaneous sample that must be dropped
    base_out = n_out;
    exp_q.push_back(-32'sd23552);
    exp_q.push_back(-32'sd23552);
    send(16'sd8192);
    t = 0;
    while (n_out < base_out + 2 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("pre_reset_outputs", n_out - base_out, 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'sd8192;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    silent = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) silent++;
      @(posedge clk); #1;
    end
    check("abort_no_output", silent, 0);
    push4(32'sd1024);
    send(16'sd8192);
    drain("drain_after_reset");

    // Continuous streaming: accepts every 37 cycles, 4 outputs in between
    push4(32'sd2048); push4(32'sd3072); push4(32'sd4096);
    in_data = 16'sd8192; in_valid = 1'b1;
    cyc = 0; n_acc = 0;
    while (n_acc < 3 && cyc < 300) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc[n_acc] = cyc;
        acc_out[n_acc] = n_out;
        n_acc++;
      end
      @(posedge clk); #1; cyc++;
      if (n_acc == 3) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("stream_accepts", n_acc, 3);
    check("stream_period_1", acc_cyc[1] - acc_cyc[0], 37);
    check("stream_period_2", acc_cyc[2] - acc_cyc[1], 37);
    check("stream_outs_1", acc_out[1] - acc_out[0], 4);
    check("stream_outs_2", acc_out[2] - acc_out[1], 4);
    drain("drain_stream");

    // Large coefficients, full-scale positive input on the second instance
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 4; i++) exp2_q.push_back(big_tbl[k < 8 ? k : 7]);
      t = 0;
      while (!in_ready2 && t < 200) begin
        @(posedge clk); #1; t++;
      end
      in_valid2 = 1'b1; in_data2 = 16'sd32767;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
    end
    t = 0;
    while (exp2_q.size() != 0 && t < 500) begin
      @(posedge clk); #1; t++;
    end
    check("drain_big", exp2_q.size(), 0);
    check("big_out_count", n_out2, 36);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_interp.md
FIR_INTERP -- requirements
Module: fir_interp

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed input sample width.
REQ-002 SHALL have parameter COEF_W, default 13: signed coefficient width.
REQ-003 SHALL have parameter SHIFT, default 13: arithmetic right shift applied to the accumulator before output.
REQ-004 SHALL have parameter COEFFS, default 32 copies of 13'sd1024 packed as 32*COEF_W bits: prototype taps h[0..31], where h[k] = COEFFS[k*COEF_W +: COEF_W].
REQ-005 SHALL have port Clock, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port Rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port In_Valid, input, 1: In_Data valid.
REQ-008 SHALL have port In_Data, input, DATA_W: signed low-rate sample.
REQ-009 SHALL have port In_Ready, output, 1: block accepts a sample.
REQ-010 SHALL have port Out_Valid, output, 1: Out_Data valid.
REQ-011 SHALL have port Out_Data, output, 32: signed interpolated sample.
REQ-012 SHALL have port Out_Ready, input, 1: downstream accepts Out_Data.

Function
REQ-013 SHALL interpolate by 4 (polyphase): each accepted x[n] yields outputs in phase order p = 0,1,2,3, with y_p = sum over j = 0..7 of h[4j+p]*x[n-j].
REQ-014 SHALL keep an 8-entry signed delay line x[0..7], where x[0] is the newest sample; an accepted sample shifts in at x[0] and x[7] is discarded.
REQ-015 SHALL implement state machine IDLE -> MAC -> OUT -> (MAC for next phase | IDLE after p = 3).
REQ-016 SHALL drive In_Ready = 1 only in IDLE; In_Valid && In_Ready at an edge accepts a sample, sets p = 0 and enters MAC.
REQ-017 MAC SHALL last exactly 8 cycles with tap counter j = 0..7, one multiply per cycle: acc <= (j == 0 ? 0 : acc) + h[4j+p]*x[j].
REQ-018 acc SHALL be 40-bit signed; products SHALL be full-precision signed and sign-extended into acc.
REQ-019 At the j = 7 edge, Out_Data SHALL be loaded with the final sum >>> SHIFT, sign-extended or processed per REQ-029, and state SHALL go to OUT.
REQ-020 Out_Valid SHALL be 1 only in OUT; Out_Data SHALL hold stable while Out_Valid && !Out_Ready.
REQ-021 On an OUT edge with Out_Ready = 1: if p < 3, p increments and state returns to MAC; otherwise state returns to IDLE.
REQ-022 First Out_Valid SHALL assert on the 8th edge after the accept edge; with Out_Ready held at 1, one input SHALL be consumed every 37 cycles.
REQ-023 Out_Data SHALL retain its last value outside OUT; In_Valid SHALL be ignored outside IDLE.
REQ-024 Back-pressure SHALL stall only OUT; the delay line SHALL NOT change outside an accept.

Reset
REQ-025 While Rst_n = 0 at a Clock edge, the block SHALL enter IDLE with p = 0, j = 0, acc = 0, all x[] = 0, Out_Data = 0 and Out_Valid = 0; In_Ready SHALL be 1 once the block is in IDLE.
REQ-026 Reset asserted in any state, including mid-MAC or in OUT, SHALL abort the frame with no further Out_Valid for it.
REQ-027 Reset SHALL take priority over a simultaneous In_Valid; that sample SHALL be dropped.

Configuration
REQ-028 Macro FIR_INTERP_SAT_EN SHALL select output saturation.
REQ-029 When FIR_INTERP_SAT_EN is defined, acc >>> SHIFT SHALL clamp to the DATA_W signed range, [-32768, 32767] at defaults; when it is undefined, bits [SHIFT+26:SHIFT] of acc SHALL be sign-extended to 32 bits with no clamping.

Verification
REQ-030 Default COEFFS, first sample 8192 after reset -> four outputs of 1024; after 8 samples of 8192 -> every output 8192.
REQ-031 Default COEFFS, 8+ samples of -32768 -> every output -32768, sign-extended to 32'hFFFF8000.
REQ-032 Out_Ready held at 0 for 5 cycles in OUT -> Out_Valid = 1 and Out_Data unchanged throughout, In_Ready = 0; release -> next phase proceeds.
REQ-033 Rst_n = 0 for 1 cycle during MAC of p = 2 -> next cycle IDLE, In_Ready = 1, Out_Valid = 0; a new sample 8192 then yields 1024 per phase, proving the delay line was cleared.
REQ-034 COEFFS all 4095, 8+ samples of 32767 -> output 32767 with FIR_INTERP_SAT_EN defined, 131036 without it.
REQ-035 In_Valid held at 1 and Out_Ready held at 1 -> In_Ready pulses exactly once every 37 cycles, with 4 Out_Valid pulses between accepts.
